alu_issue: RTL and testbench

- Operand-issue and writeback stage directly upstream of the team's 16-bit ALU.
- Accepts 3-operand register instructions over a valid/ready handshake and reads operands from an internal register file, with forwarding.
- Drives registered opcode and operands into the ALU, then writes the ALU result and flags back on the next edge.
- Contains a small RUN/TRAP state machine that halts issue on signed overflow when trapping is enabled.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_regfile.sv | 47 ++++
 rtl/alu_issue.sv | 161 ++++++++++++++++
 tb/tb_alu_issue.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU issue stage: opcodes, flag positions,
// issue FSM states and instruction field slicing.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_INC   = 3'b101,
        OP_PASSA = 3'b110,
        OP_PASSB = 3'b111
    } alu_op_e;

    localparam int FLAG_OVF  = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    // Instruction layout is {opcode, rd, ra, rb}; register slot 0 is rb, 1 is ra, 2 is rd.
    function automatic logic [2:0] instr_opcode(input logic [31:0] instr, input int aw);
        return 3'((instr >> (3 * aw)) & 32'd7);
    endfunction

    function automatic logic [7:0] instr_reg(input logic [31:0] instr, input int aw, input int slot);
        return 8'((instr >> (slot * aw)) & ((32'd1 << aw) - 32'd1));
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the issue stage: two operand read ports, a debug read port,
// and a write port where a retire beats an external write to the same entry.
module alu_regfile #(
    parameter int BW   = 16,
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_ra_addr,
    output logic [BW-1:0] o_ra_data,
    input  logic [AW-1:0] i_rb_addr,
    output logic [BW-1:0] o_rb_data,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [BW-1:0] o_dbg_data,
    input  logic          i_ret_we,
    input  logic [AW-1:0] i_ret_addr,
    input  logic [BW-1:0] i_ret_data,
    input  logic          i_ext_we,
    input  logic [AW-1:0] i_ext_addr,
    input  logic [BW-1:0] i_ext_data
);

    logic [BW-1:0] r_mem [NREG];

    // Both writers may land on different entries in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (i_ret_we && (i_ret_addr == AW'(i))) begin
                    r_mem[i] <= i_ret_data;
                end else if (i_ext_we && (i_ext_addr == AW'(i))) begin
                    r_mem[i] <= i_ext_data;
                end
            end
        end
    end

    assign o_ra_data  = r_mem[i_ra_addr];
    assign o_rb_data  = r_mem[i_rb_addr];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Operand-issue and writeback stage in front of the 16-bit ALU: reads operands
// with forwarding, retires results, and traps on signed overflow when enabled.
module alu_issue
    import alu_pkg::*;
#(
    parameter  int BW    = 16,
    parameter  int NREG  = 8,
    parameter  int CNT_W = 16,
    localparam int AW    = $clog2(NREG),
    localparam int IW    = 3 + 3 * AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_instr_valid,
    output logic             o_instr_ready,
    input  logic [IW-1:0]    i_instr,
    output logic [2:0]       o_alu_op,
    output logic [BW-1:0]    o_alu_a,
    output logic [BW-1:0]    o_alu_b,
    input  logic [BW:0]      i_alu_out,
    input  logic [2:0]       i_alu_flags,
    output logic             o_issue_valid,
    input  logic             i_trap_en,
    input  logic             i_trap_clr,
    output logic             o_trap,
    input  logic             i_ext_we,
    input  logic [AW-1:0]    i_ext_addr,
    input  logic [BW-1:0]    i_ext_data,
    input  logic [AW-1:0]    i_dbg_addr,
    output logic [BW-1:0]    o_dbg_data,
    output logic [2:0]       o_flags_q,
    output logic [CNT_W-1:0] o_retired
);

    state_e           r_state;
    state_e           w_state_next;
    alu_op_e          r_alu_op;
    logic [BW-1:0]    r_alu_a;
    logic [BW-1:0]    r_alu_b;
    logic             r_issue_valid;
    logic [AW-1:0]    r_rd_q;
    logic [2:0]       r_flags_q;
    logic [CNT_W-1:0] r_retired;

    logic             w_ovf_hit;
    logic             w_instr_ready;
    logic             w_accept;
    logic             w_retire;
    logic [2:0]       w_opcode;
    logic [AW-1:0]    w_rd;
    logic [AW-1:0]    w_ra;
    logic [AW-1:0]    w_rb;
    logic [BW-1:0]    w_rf_a;
    logic [BW-1:0]    w_rf_b;
    logic [BW-1:0]    w_fwd_a;
    logic [BW-1:0]    w_fwd_b;
    logic [BW-1:0]    w_result;
    logic             w_unused_carry;

    assign w_opcode = instr_opcode(32'(i_instr), AW);
    assign w_rd     = AW'(instr_reg(32'(i_instr), AW, 2));
    assign w_ra     = AW'(instr_reg(32'(i_instr), AW, 1));
    assign w_rb     = AW'(instr_reg(32'(i_instr), AW, 0));

    assign w_result       = i_alu_out[BW-1:0];
    assign w_unused_carry = i_alu_out[BW];

    assign w_ovf_hit = r_issue_valid & i_trap_en & i_alu_flags[FLAG_OVF];
    assign w_retire  = r_issue_valid & ~w_ovf_hit;
    assign w_accept  = i_instr_valid & w_instr_ready;

    alu_regfile #(
        .BW   (BW),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_ra_addr  (w_ra),
        .o_ra_data  (w_rf_a),
        .i_rb_addr  (w_rb),
        .o_rb_data  (w_rf_b),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data),
        .i_ret_we   (w_retire),
        .i_ret_addr (r_rd_q),
        .i_ret_data (w_result),
        .i_ext_we   (i_ext_we),
        .i_ext_addr (i_ext_addr),
        .i_ext_data (i_ext_data)
    );

    // The in-flight result bypasses the register file it is about to be written into.
    assign w_fwd_a = (w_retire && (r_rd_q == w_ra)) ? w_result : w_rf_a;
    assign w_fwd_b = (w_retire && (r_rd_q == w_rb)) ? w_result : w_rf_b;

    always_comb begin
        w_state_next  = r_state;
        w_instr_ready = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_instr_ready = ~w_ovf_hit;
                if (w_ovf_hit) begin
                    w_state_next = ST_TRAP;
                end
            end
            ST_TRAP: begin
                if (i_trap_clr) begin
                    w_state_next = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ALU operand registers hold their last values when nothing is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_valid <= 1'b0;
            r_alu_op      <= OP_ADD;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_rd_q        <= '0;
        end else begin
            r_issue_valid <= w_accept;
            if (w_accept) begin
                r_alu_op <= alu_op_e'(w_opcode);
                r_alu_a  <= w_fwd_a;
                r_alu_b  <= w_fwd_b;
                r_rd_q   <= w_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags_q <= '0;
            r_retired <= '0;
        end else if (w_retire) begin
            r_flags_q <= {i_alu_flags[FLAG_OVF], i_alu_flags[FLAG_NEG], i_alu_flags[FLAG_ZERO]};
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign o_instr_ready = w_instr_ready;
    assign o_alu_op      = r_alu_op;
    assign o_alu_a       = r_alu_a;
    assign o_alu_b       = r_alu_b;
    assign o_issue_valid = r_issue_valid;
    assign o_trap        = (r_state == ST_TRAP);
    assign o_flags_q     = r_flags_q;
    assign o_retired     = r_retired;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: an ALU model closes the loop, an architectural model
// predicts every output each cycle, and directed scenarios pin known values.
module tb_alu_issue;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instrValid = 1'b0;
    logic [11:0] instr = '0;
    logic        trapEn = 1'b0;
    logic        trapClr = 1'b0;
    logic        extWe = 1'b0;
    logic [2:0]  extAddr = '0;
    logic [15:0] extData = '0;
    logic [2:0]  dbgAddr = '0;

    logic        instrReady;
    logic [2:0]  aluOp;
    logic [15:0] aluA;
    logic [15:0] aluB;
    logic [16:0] aluOut;
    logic [2:0]  aluFlags;
    logic        issueValid;
    logic        trap;
    logic [15:0] dbgData;
    logic [2:0]  flagsQ;
    logic [3:0]  retired;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue #(.BW(16), .NREG(8), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_instr_valid (instrValid),
        .o_instr_ready (instrReady),
        .i_instr       (instr),
        .o_alu_op      (aluOp),
        .o_alu_a       (aluA),
        .o_alu_b       (aluB),
        .i_alu_out     (aluOut),
        .i_alu_flags   (aluFlags),
        .o_issue_valid (issueValid),
        .i_trap_en     (trapEn),
        .i_trap_clr    (trapClr),
        .o_trap        (trap),
        .i_ext_we      (extWe),
        .i_ext_addr    (extAddr),
        .i_ext_data    (extData),
        .i_dbg_addr    (dbgAddr),
        .o_dbg_data    (dbgData),
        .o_flags_q     (flagsQ),
        .o_retired     (retired)
    );

    // Signed 17-bit ALU: returns {ovf, neg, zero, result}.
    function automatic logic [19:0] aluCalc(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] ea;
        logic [16:0] eb;
        logic [16:0] res;
        ea = {a[15], a};
        eb = {b[15], b};
        case (op)
            3'd0:    res = ea + eb;
            3'd1:    res = ea - eb;
            3'd2:    res = ea & eb;
            3'd3:    res = ea | eb;
            3'd4:    res = ea ^ eb;
            3'd5:    res = ea + 17'd1;
            3'd6:    res = ea;
            default: res = eb;
        endcase
        return {res[16] ^ res[15], res[16], res == 17'd0, res};
    endfunction

    assign {aluFlags, aluOut} = aluCalc(aluOp, aluA, aluB);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Architectural model: register values, the one instruction in flight, trap state, counters.
    logic [15:0] mRf [8];
    logic [15:0] postRf [8];
    logic [15:0] newRf [8];
    bit          mValid;
    bit          mTrap;
    logic [2:0]  mOp;
    logic [2:0]  mRd;
    logic [15:0] mA;
    logic [15:0] mB;
    logic [2:0]  mFlags;
    int          mRetired;
    logic [19:0] mr;
    bit          mOvf;
    bit          mRetire;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mRf[i] = '0;
            mValid = 0; mTrap = 0; mOp = '0; mRd = '0; mA = '0; mB = '0;
            mFlags = '0; mRetired = 0;
        end else begin
            mr = aluCalc(mOp, mA, mB);
            mOvf = mValid && trapEn && mr[19];
            mRetire = mValid && !mOvf;
            postRf = mRf;
            if (mRetire) postRf[mRd] = mr[15:0];
            newRf = mRf;
            if (extWe) newRf[extAddr] = extData;
            if (mRetire) newRf[mRd] = mr[15:0];
            if (instrValid && !mTrap && !mOvf) begin
                mValid = 1;
                mOp = instr[11:9];
                mRd = instr[8:6];
                mA = postRf[instr[5:3]];
                mB = postRf[instr[2:0]];
            end else begin
                mValid = 0;
            end
            if (mRetire) begin
                mFlags = mr[19:17];
                mRetired = (mRetired + 1) % 16;
            end
            if (mOvf) mTrap = 1;
            else if (mTrap && trapClr) mTrap = 0;
            mRf = newRf;
        end
    end

    logic [19:0] cr;
    always @(negedge clk) begin
        if (!rst) begin
            cr = aluCalc(mOp, mA, mB);
            check("instr_ready", instrReady, !mTrap && !(mValid && trapEn && cr[19]));
            check("issue_valid", issueValid, mValid);
            check("alu_op", aluOp, mOp);
            check("alu_a", aluA, mA);
            check("alu_b", aluB, mB);
            check("trap", trap, mTrap);
            check("flags_q", flagsQ, mFlags);
            check("retired", retired, mRetired % 16);
            check("dbg_data", dbgData, mRf[dbgAddr]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic extWrite(input logic [2:0] addr, input logic [15:0] data);
        extWe = 1'b1;
        extAddr = addr;
        extData = data;
        tick();
        extWe = 1'b0;
    endtask

    task automatic sendInstr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                             input logic [2:0] rb, output int waits);
        bit accepted;
        accepted = 0;
        waits = 0;
        instrValid = 1'b1;
        instr = {op, rd, ra, rb};
        while (!accepted && waits < 64) begin
            @(negedge clk);
            if (instrReady) accepted = 1;
            else waits++;
            tick();
        end
        if (!accepted) check("accept_timeout", 0, 1);
        instrValid = 1'b0;
    endtask

    task automatic readReg(input logic [2:0] addr, input logic [15:0] exp, input string name);
        dbgAddr = addr;
        #1;
        check(name, dbgData, exp);
    endtask

    initial begin
        int w1;
        int w2;
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w1;
        int w2;
        #3;
        tick();
        doReset();

        // Overflowing add retires when trapping is disabled.
        trapEn = 1'b0;
        extWrite(3'd1, 16'h7FFF);
        extWrite(3'd2, 16'h0001);
        sendInstr(OP_ADD, 3'd3, 3'd1, 3'd2, w1);
        tick();
        readReg(3'd3, 16'h8000, "ovf_noTrap_r3");
        check("ovf_noTrap_flags", flagsQ, 3'b100);
        check("ovf_noTrap_retired", retired, 1);

        // Back-to-back dependent instructions with forwarding.
        doReset();
        extWrite(3'd1, 16'd5);
        extWrite(3'd2, 16'd3);
        sendInstr(OP_ADD, 3'd3, 3'd1, 3'd2, w1);
        sendInstr(OP_SUB, 3'd4, 3'd3, 3'd2, w2);
        check("fwd_no_stall", w1 + w2, 0);
        tick();
        readReg(3'd4, 16'h0005, "fwd_r4");
        readReg(3'd3, 16'h0008, "fwd_r3");
        check("fwd_retired", retired, 2);

        // Overflow trap, then clear and resume.
        doReset();
        extWrite(3'd1, 16'h7FFF);
        extWrite(3'd2, 16'h0001);
        trapEn = 1'b1;
        sendInstr(OP_ADD, 3'd3, 3'd1, 3'd2, w1);
        instrValid = 1'b1;
        instr = {OP_ADD, 3'd4, 3'd2, 3'd2};
        @(negedge clk);
        check("trap_ovf_ready", instrReady, 0);
        tick();
        tick();
        check("trap_state", trap, 1);
        check("trap_ready", instrReady, 0);
        check("trap_issue_valid", issueValid, 0);
        check("trap_retired", retired, 0);
        check("trap_flags", flagsQ, 3'b000);
        readReg(3'd3, 16'h0000, "trap_r3");
        trapClr = 1'b1;
        tick();
        trapClr = 1'b0;
        check("trap_cleared", trap, 0);
        sendInstr(OP_ADD, 3'd4, 3'd2, 3'd2, w1);
        tick();
        readReg(3'd4, 16'h0002, "trap_resume_r4");
        check("trap_resume_retired", retired, 1);
        trapEn = 1'b0;

        // Retire and external write to the same register on one edge.
        doReset();
        extWrite(3'd5, 16'h1234);
        sendInstr(OP_XOR, 3'd5, 3'd5, 3'd5, w1);
        extWe = 1'b1;
        extAddr = 3'd5;
        extData = 16'hBEEF;
        tick();
        extWe = 1'b0;
        readReg(3'd5, 16'h0000, "collide_r5");
        check("collide_flags", flagsQ, 3'b001);

        // Retired counter wraps at 16.
        doReset();
        for (int i = 0; i < 17; i++) sendInstr(OP_INC, 3'd1, 3'd1, 3'd0, w1);
        tick();
        check("wrap_retired", retired, 1);
        readReg(3'd1, 16'd17, "wrap_r1");

        // Asynchronous reset with an instruction in flight.
        doReset();
        extWrite(3'd2, 16'h0042);
        sendInstr(OP_ADD, 3'd1, 3'd2, 3'd2, w1);
        sendInstr(OP_ADD, 3'd3, 3'd2, 3'd2, w1);
        rst = 1'b1;
        #1;
        check("async_issue_valid", issueValid, 0);
        check("async_alu_a", aluA, 0);
        check("async_retired", retired, 0);
        check("async_flags", flagsQ, 0);
        for (int i = 0; i < 8; i++) readReg(3'(i), 16'h0000, "async_rf");
        rst = 1'b0;
        extWrite(3'd1, 16'd10);
        extWrite(3'd2, 16'd20);
        sendInstr(OP_ADD, 3'd3, 3'd1, 3'd2, w1);
        tick();
        readReg(3'd3, 16'd30, "post_reset_r3");
        check("post_reset_retired", retired, 1);

        // Randomized traffic against the model.
        doReset();
        for (int i = 0; i < 8; i++) extWrite(3'(i), 16'($urandom));
        for (int i = 0; i < 3000; i++) begin
            instrValid = ($urandom % 4) != 0;
            instr = 12'($urandom);
            trapEn = ($urandom % 8) == 0;
            trapClr = ($urandom % 4) == 0;
            extWe = ($urandom % 4) == 0;
            extAddr = 3'($urandom);
            extData = 16'($urandom);
            dbgAddr = 3'($urandom);
            tick();
        end
        instrValid = 1'b0;
        trapEn = 1'b0;
        trapClr = 1'b0;
        extWe = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
